// File: rtl/river_crossing_ctrl_if.sv
// Crossing request handshake between the player and the river crossing controller.
// The master presents a crossing type; the controller accepts it when ready.
interface river_crossing_ctrl_if;
  logic       move_valid;
  logic [1:0] move_sel;
  logic       move_ready;

  modport master (
    output move_valid,
    output move_sel,
    input  move_ready
  );

  modport slave (
    input  move_valid,
    input  move_sel,
    output move_ready
  );
endinterface

// File: rtl/river_crossing_ctrl.sv
// Farmer/wolf/goat/cabbage crossing sequencer with unattended-bank alarm.
// pos holds {F, C, G, W}; a bit of 1 means that actor is on the far bank.
module river_crossing_ctrl #(
  parameter int MAX_MOVES = 15,
  parameter int CNT_W     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  restart,
  river_crossing_ctrl_if.slave  bus,
  output logic [3:0]            pos,
  output logic                  alarm,
  output logic                  err,
  output logic                  win,
  output logic                  lose,
  output logic [CNT_W-1:0]      move_cnt,
  output logic [1:0]            state
);

  typedef enum logic [1:0] {
    PLAY  = 2'b00,
    CHECK = 2'b01,
    WIN   = 2'b10,
    LOSE  = 2'b11
  } state_t;

  state_t     st;
  logic [2:0] item;
  logic       legal;
  logic       u_c;
  logic       u_g;
  logic       u_w;
  logic       unsafe;

  // item is the one-hot passenger among {C, G, W}; zero when the farmer rows alone
  always_comb begin
    item = 3'b000;
    unique case (bus.move_sel)
      2'b01:   item = 3'b001;
      2'b10:   item = 3'b010;
      2'b11:   item = 3'b100;
      default: item = 3'b000;
    endcase
  end

  assign legal  = (item == 3'b000) || ((|(pos[2:0] & item)) == pos[3]);
  assign u_c    = pos[2] ^ pos[3];
  assign u_g    = pos[1] ^ pos[3];
  assign u_w    = pos[0] ^ pos[3];
  assign unsafe = (u_g & u_w) | (u_g & u_c);

  assign bus.move_ready = (st == PLAY);
  assign win            = (st == WIN);
  assign lose           = (st == LOSE);
  assign state          = st;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st       <= PLAY;
      pos      <= 4'b0000;
      move_cnt <= '0;
      alarm    <= 1'b0;
      err      <= 1'b0;
    end else begin
      err <= 1'b0;
      if (restart) begin
        st       <= PLAY;
        pos      <= 4'b0000;
        move_cnt <= '0;
        alarm    <= 1'b0;
      end else begin
        unique case (st)
          PLAY: begin
            if (bus.move_valid) begin
              if (legal) begin
                pos      <= pos ^ {1'b1, item};
                move_cnt <= move_cnt + CNT_W'(1);
                st       <= CHECK;
              end else begin
                err <= 1'b1;
              end
            end
          end
          CHECK: begin
            if (unsafe) begin
              st    <= LOSE;
              alarm <= 1'b1;
            end else if (pos == 4'b1111) begin
              st <= WIN;
            end else if (move_cnt == CNT_W'(MAX_MOVES)) begin
              st <= LOSE;
            end else begin
              st <= PLAY;
            end
          end
          WIN:  st <= WIN;
          LOSE: st <= LOSE;
        endcase
      end
    end
  end

endmodule
